// File: rtl/grf_wb_stage.sv
// ----------------------------------------------------------------------------
// grf_wb_stage
//
// Writeback stage sitting directly in front of the 16x32 general register
// file write port. Each cycle it picks at most one of two producers, an ALU
// result or a memory load return, shapes the data, and presents a registered
// write (address, byte enables, data, active-low chip select) to the register
// file one cycle after the handshake.
//
// Loads are normally granted ahead of ALU results. A starve counter tracks how
// many loads in a row have been taken while an ALU result was waiting. Once it
// reaches STARVE_MAX, the ALU result is forced through.
//
// Load returns are extracted from the raw aligned memory word by size and byte
// offset, then zero-extended, sign-extended or inserted into the low lanes.
// A misaligned load still completes its handshake, but it is dropped and
// flagged on o_misalign. With ZERO_REG_EN set, writes to R0 are accepted and
// silently squashed.
//
// Parameters
//   STARVE_MAX   consecutive load grants allowed while an ALU result waits
//                (1..15)
//   ZERO_REG_EN  1: writes to R0 are accepted but never reach the file
//
// Ports
//   i_clk        clock
//   i_rst_b      synchronous active-low reset
//   i_clk_en     global clock enable; low freezes all state and drops readies
//   i_alu_valid  ALU result valid
//   o_alu_rdy    ALU result accepted this cycle (combinational)
//   i_alu_rd     ALU destination register
//   i_alu_data   ALU result
//   i_ld_valid   load return valid
//   o_ld_rdy     load return accepted this cycle (combinational)
//   i_ld_rd      load destination register
//   i_ld_data    raw aligned memory word
//   i_ld_boff    byte offset of the access
//   i_ld_size    00 byte, 01 half, 10/11 word
//   i_ld_mode    00 zero-extend, 01 sign-extend, 10 insert, 11 zero-extend
//   o_waddr      register file write address
//   o_wen        register file byte write enables
//   o_din        register file write data
//   o_cs_b       register file chip select, active low
//   o_misalign   one-cycle pulse: a misaligned load was dropped
// ----------------------------------------------------------------------------
module grf_wb_stage #(
    parameter int STARVE_MAX  = 3,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_clk_en,

    input  logic        i_alu_valid,
    output logic        o_alu_rdy,
    input  logic [3:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,

    input  logic        i_ld_valid,
    output logic        o_ld_rdy,
    input  logic [3:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    input  logic [1:0]  i_ld_boff,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_mode,

    output logic [3:0]  o_waddr,
    output logic [3:0]  o_wen,
    output logic [31:0] o_din,
    output logic        o_cs_b,
    output logic        o_misalign
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_INSERT = 2'b10;

    logic [3:0]  starve_cnt;

    logic        en;
    logic        force_alu;
    logic        ld_acc;
    logic        alu_acc;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_misaligned;
    logic [3:0]  ld_wen;
    logic [31:0] ld_val;

    logic        wr_acc;
    logic [3:0]  wr_rd;
    logic [3:0]  wr_wen;
    logic [31:0] wr_data;
    logic        wr_squash;

    // Arbitration. Loads win by default. Once the ALU has waited through
    // STARVE_MAX load grants, it takes the port and the load is held off.
    // The two readies can never both accept in the same cycle.
    always_comb begin
        en        = i_clk_en & i_rst_b;
        force_alu = i_alu_valid & (starve_cnt == STARVE_LIM);
        o_ld_rdy  = en & ~force_alu;
        o_alu_rdy = en & (~i_ld_valid | force_alu);
        ld_acc    = i_ld_valid & o_ld_rdy;
        alu_acc   = i_alu_valid & o_alu_rdy;
    end

    // Load extraction and extension. Misalignment is decided here as well,
    // because it depends only on the load's own size and offset.
    always_comb begin
        ld_byte       = i_ld_data[8*i_ld_boff +: 8];
        ld_half       = i_ld_boff[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        ld_misaligned = ((i_ld_size == SIZE_HALF) && i_ld_boff[0]) ||
                        (i_ld_size[1] && (i_ld_boff != 2'b00));
        ld_wen        = 4'b1111;
        ld_val        = i_ld_data;
        case (i_ld_size)
            SIZE_BYTE: begin
                if (i_ld_mode == MODE_INSERT) begin
                    ld_wen = 4'b0001;
                    ld_val = {24'b0, ld_byte};
                end else if (i_ld_mode == MODE_SIGN) begin
                    ld_val = {{24{ld_byte[7]}}, ld_byte};
                end else begin
                    ld_val = {24'b0, ld_byte};
                end
            end
            SIZE_HALF: begin
                if (i_ld_mode == MODE_INSERT) begin
                    ld_wen = 4'b0011;
                    ld_val = {16'b0, ld_half};
                end else if (i_ld_mode == MODE_SIGN) begin
                    ld_val = {{16{ld_half[15]}}, ld_half};
                end else begin
                    ld_val = {16'b0, ld_half};
                end
            end
            default: begin
                ld_wen = 4'b1111;
                ld_val = i_ld_data;
            end
        endcase
    end

    // Select the winning item's write fields and decide whether it is dropped.
    // A dropped item still completes its handshake, but it never asserts the
    // chip select.
    always_comb begin
        wr_acc    = alu_acc | ld_acc;
        wr_rd     = alu_acc ? i_alu_rd : i_ld_rd;
        wr_wen    = alu_acc ? 4'b1111 : ld_wen;
        wr_data   = alu_acc ? i_alu_data : ld_val;
        wr_squash = (ld_acc & ld_misaligned) |
                    (ZERO_REG_EN & (wr_rd == 4'd0));
    end

    // Starve counter. It counts loads taken past a waiting ALU result and
    // saturates at the limit. It clears whenever the ALU gets through or
    // stops asking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            starve_cnt <= 4'd0;
        end else if (i_clk_en) begin
            if (ld_acc && i_alu_valid) begin
                if (starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end else if (alu_acc || !i_alu_valid) begin
                starve_cnt <= 4'd0;
            end
        end
    end

    // Register file write port. An accepted item is presented in the
    // following cycle. Without an acceptance, the chip select and byte enables
    // drop, while the address and data keep their last values. A disabled
    // clock freezes everything, including a pending misalign pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            o_waddr    <= 4'd0;
            o_wen      <= 4'b0000;
            o_din      <= 32'd0;
            o_cs_b     <= 1'b1;
            o_misalign <= 1'b0;
        end else if (i_clk_en) begin
            if (wr_acc) begin
                o_waddr    <= wr_rd;
                o_din      <= wr_data;
                o_wen      <= wr_squash ? 4'b0000 : wr_wen;
                o_cs_b     <= wr_squash;
                o_misalign <= ld_acc & ld_misaligned;
            end else begin
                o_wen      <= 4'b0000;
                o_cs_b     <= 1'b1;
                o_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_grf_wb_stage
//
// Two instances share one set of inputs:
//   dut0  STARVE_MAX=3, ZERO_REG_EN=0
//   dut1  STARVE_MAX=2, ZERO_REG_EN=1
//
// A behavioural model of the writeback rules (grant choice, starve count and
// the expected register-file write) runs alongside. Every negedge, both
// instances are compared against it. Directed sequences add literal
// expectations. Randomized traffic follows.
// ----------------------------------------------------------------------------
module tb_grf_wb_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_b;
    logic        i_clk_en;
    logic        i_alu_valid;
    logic [3:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_valid;
    logic [3:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic [1:0]  i_ld_boff;
    logic [1:0]  i_ld_size;
    logic [1:0]  i_ld_mode;

    logic        alu_rdy0, ld_rdy0, cs_b0, mis0;
    logic [3:0]  waddr0, wen0;
    logic [31:0] din0;
    logic        alu_rdy1, ld_rdy1, cs_b1, mis1;
    logic [3:0]  waddr1, wen1;
    logic [31:0] din1;

    int tests_run = 0;
    int tests_failed = 0;
    bit cmp_on = 1'b0;

    always #5 i_clk = ~i_clk;

    grf_wb_stage #(.STARVE_MAX(3), .ZERO_REG_EN(1'b0)) dut0 (
        .i_clk(i_clk), .i_rst_b(i_rst_b), .i_clk_en(i_clk_en),
        .i_alu_valid(i_alu_valid), .o_alu_rdy(alu_rdy0),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_valid(i_ld_valid), .o_ld_rdy(ld_rdy0),
        .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data), .i_ld_boff(i_ld_boff),
        .i_ld_size(i_ld_size), .i_ld_mode(i_ld_mode),
        .o_waddr(waddr0), .o_wen(wen0), .o_din(din0),
        .o_cs_b(cs_b0), .o_misalign(mis0)
    );

    grf_wb_stage #(.STARVE_MAX(2), .ZERO_REG_EN(1'b1)) dut1 (
        .i_clk(i_clk), .i_rst_b(i_rst_b), .i_clk_en(i_clk_en),
        .i_alu_valid(i_alu_valid), .o_alu_rdy(alu_rdy1),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_valid(i_ld_valid), .o_ld_rdy(ld_rdy1),
        .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data), .i_ld_boff(i_ld_boff),
        .i_ld_size(i_ld_size), .i_ld_mode(i_ld_mode),
        .o_waddr(waddr1), .o_wen(wen1), .o_din(din1),
        .o_cs_b(cs_b1), .o_misalign(mis1)
    );

    // ---------------- behavioural model ----------------
    int          m_cnt   [2];
    bit          m_cs_b  [2];
    bit   [3:0]  m_wen   [2];
    bit   [3:0]  m_waddr [2];
    bit   [31:0] m_din   [2];
    bit          m_mis   [2];

    function automatic int starveMax(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic bit zeroRegEn(input int i);
        return (i == 1);
    endfunction

    // Readies for instance i, given the current inputs and the starve count.
    function automatic void grants(input int i, output bit ldr, output bit alur);
        bit en;
        bit frc;
        en   = i_clk_en && i_rst_b;
        frc  = i_alu_valid && (m_cnt[i] == starveMax(i));
        ldr  = en && !frc;
        alur = en && (!i_ld_valid || frc);
    endfunction

    // Load shaping from plain arithmetic on the memory word.
    function automatic void ldCalc(input bit [31:0] d, input int boff,
                                   input int size, input int mode,
                                   output bit mis, output bit [3:0] wen,
                                   output bit [31:0] val);
        longint unsigned bv;
        longint unsigned hv;
        bv  = (longint'(d) >> (8 * boff)) % 256;
        hv  = (longint'(d) >> (16 * (boff / 2))) % 65536;
        mis = (size == 1 && (boff % 2) == 1) || (size >= 2 && boff != 0);
        wen = 4'hF;
        val = d;
        if (size == 0) begin
            val = 32'(bv);
            if (mode == 2) wen = 4'h1;
            else if (mode == 1 && bv >= 128) val = 32'(bv + 64'hFFFFFF00);
        end else if (size == 1) begin
            val = 32'(hv);
            if (mode == 2) wen = 4'h3;
            else if (mode == 1 && hv >= 32768) val = 32'(hv + 64'hFFFF0000);
        end
    endfunction

    always @(posedge i_clk) begin
        for (int i = 0; i < 2; i++) begin
            bit ldr, alur, la, aa, mis, sq;
            bit [3:0]  w;
            bit [31:0] v;
            bit [3:0]  rd;
            grants(i, ldr, alur);
            la = i_ld_valid && ldr;
            aa = i_alu_valid && alur;
            if (!i_rst_b) begin
                m_cnt[i] = 0; m_cs_b[i] = 1; m_wen[i] = 0;
                m_waddr[i] = 0; m_din[i] = 0; m_mis[i] = 0;
            end else if (i_clk_en) begin
                if (la && i_alu_valid)
                    m_cnt[i] = (m_cnt[i] + 1 > starveMax(i)) ? starveMax(i) : m_cnt[i] + 1;
                else if (aa || !i_alu_valid)
                    m_cnt[i] = 0;
                if (la || aa) begin
                    if (aa) begin
                        rd = i_alu_rd; w = 4'hF; v = i_alu_data; mis = 0;
                    end else begin
                        rd = i_ld_rd;
                        ldCalc(i_ld_data, int'(i_ld_boff), int'(i_ld_size),
                               int'(i_ld_mode), mis, w, v);
                    end
                    sq = mis || (zeroRegEn(i) && rd == 0);
                    m_waddr[i] = rd;
                    m_din[i]   = v;
                    m_wen[i]   = sq ? 4'h0 : w;
                    m_cs_b[i]  = sq;
                    m_mis[i]   = mis;
                end else begin
                    m_cs_b[i] = 1; m_wen[i] = 0; m_mis[i] = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                bit ldr, alur;
                grants(i, ldr, alur);
                checkOutput($sformatf("dut%0d.ld_rdy", i),
                            32'(i == 0 ? ld_rdy0 : ld_rdy1), 32'(ldr));
                checkOutput($sformatf("dut%0d.alu_rdy", i),
                            32'(i == 0 ? alu_rdy0 : alu_rdy1), 32'(alur));
                checkOutput($sformatf("dut%0d.cs_b", i),
                            32'(i == 0 ? cs_b0 : cs_b1), 32'(m_cs_b[i]));
                checkOutput($sformatf("dut%0d.wen", i),
                            32'(i == 0 ? wen0 : wen1), 32'(m_wen[i]));
                checkOutput($sformatf("dut%0d.misalign", i),
                            32'(i == 0 ? mis0 : mis1), 32'(m_mis[i]));
                if (!m_cs_b[i]) begin
                    checkOutput($sformatf("dut%0d.waddr", i),
                                32'(i == 0 ? waddr0 : waddr1), 32'(m_waddr[i]));
                    checkOutput($sformatf("dut%0d.din", i),
                                (i == 0 ? din0 : din1), m_din[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit rst_b, input bit clk_en,
                                 input bit av, input bit [3:0] ard,
                                 input bit [31:0] adata,
                                 input bit lv, input bit [3:0] lrd,
                                 input bit [31:0] ldata, input bit [1:0] boff,
                                 input bit [1:0] size, input bit [1:0] mode);
        i_rst_b = rst_b; i_clk_en = clk_en;
        i_alu_valid = av; i_alu_rd = ard; i_alu_data = adata;
        i_ld_valid = lv; i_ld_rd = lrd; i_ld_data = ldata;
        i_ld_boff = boff; i_ld_size = size; i_ld_mode = mode;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic loadOnly(input bit [31:0] d, input bit [1:0] boff,
                            input bit [1:0] size, input bit [1:0] mode);
        applyStimulus(1, 1, 0, 0, 0, 1, 4'd7, d, boff, size, mode);
    endtask

    bit expAlu [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        // Reset with both producers asking.
        applyStimulus(0, 1, 1, 4'd1, 32'h11111111, 1, 4'd2, 32'h22222222, 0, 2, 0);
        checkOutput("reset ld_rdy", 32'(ld_rdy0), 0);
        checkOutput("reset alu_rdy", 32'(alu_rdy0), 0);
        stepCycle();
        cmp_on = 1'b1;
        stepCycle();
        checkOutput("reset cs_b", 32'(cs_b0), 1);
        checkOutput("reset wen", 32'(wen0), 0);

        // Release: load granted first.
        applyStimulus(1, 1, 1, 4'd1, 32'h11111111, 1, 4'd2, 32'h22222222, 0, 2, 0);
        checkOutput("release ld_rdy", 32'(ld_rdy0), 1);
        checkOutput("release alu_rdy", 32'(alu_rdy0), 0);
        stepCycle();

        // Plain ALU write.
        applyStimulus(1, 1, 1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        checkOutput("alu alone rdy", 32'(alu_rdy0), 1);
        stepCycle();
        idle();
        checkOutput("alu cs_b", 32'(cs_b0), 0);
        checkOutput("alu waddr", 32'(waddr0), 5);
        checkOutput("alu wen", 32'(wen0), 32'hF);
        checkOutput("alu din", din0, 32'hDEADBEEF);
        stepCycle();
        checkOutput("alu cs_b after", 32'(cs_b0), 1);

        // Load shaping on 0x80FF7F01.
        loadOnly(32'h80FF7F01, 2'd3, 2'b00, 2'b01);
        stepCycle();
        checkOutput("byte sext din", din0, 32'hFFFFFF80);
        checkOutput("byte sext wen", 32'(wen0), 32'hF);
        loadOnly(32'h80FF7F01, 2'd2, 2'b01, 2'b10);
        stepCycle();
        checkOutput("half ins din", din0, 32'h000080FF);
        checkOutput("half ins wen", 32'(wen0), 32'h3);
        loadOnly(32'h80FF7F01, 2'd1, 2'b00, 2'b00);
        stepCycle();
        checkOutput("byte zext din", din0, 32'h0000007F);
        checkOutput("byte zext cs_b", 32'(cs_b0), 0);

        // Misaligned half.
        loadOnly(32'h80FF7F01, 2'd1, 2'b01, 2'b00);
        checkOutput("misalign ld_rdy", 32'(ld_rdy0), 1);
        stepCycle();
        idle();
        checkOutput("misalign cs_b", 32'(cs_b0), 1);
        checkOutput("misalign pulse", 32'(mis0), 1);
        stepCycle();
        checkOutput("misalign cleared", 32'(mis0), 0);

        // Starvation: L,L,L,A,L,L,L,A on dut0.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 1, 1, 4'(k + 1), 32'(k * 3), 1, 4'(k + 8),
                          32'h01020304 + 32'(k), 0, 2, 0);
            checkOutput($sformatf("starve grant %0d", k), 32'(alu_rdy0),
                        32'(expAlu[k]));
            stepCycle();
        end

        // Clock enable low mid-stream.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 1, 4'd3, 32'hCAFE0000, 1, 4'd4, 32'h12345678, 0, 2, 0);
            checkOutput("clk_en low rdy", 32'(ld_rdy0 | alu_rdy0), 0);
            stepCycle();
        end
        applyStimulus(1, 1, 1, 4'd3, 32'hCAFE0000, 1, 4'd4, 32'h12345678, 0, 2, 0);
        stepCycle();

        // R0 squash on dut1 only.
        applyStimulus(1, 1, 1, 4'd0, 32'h55AA55AA, 0, 0, 0, 0, 0, 0);
        checkOutput("r0 alu_rdy", 32'(alu_rdy1), 1);
        stepCycle();
        idle();
        checkOutput("r0 squash cs_b", 32'(cs_b1), 1);
        checkOutput("r0 squash wen", 32'(wen1), 0);
        checkOutput("r0 written dut0", 32'(cs_b0), 0);
        stepCycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
                          ($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
                          2'($urandom), 2'($urandom), 2'($urandom));
            stepCycle();
        end

        @(negedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/grf_wb_stage.md
Name: grf_wb_stage

Overview:
- Writeback stage directly upstream of the 16x32 1-write/2-read general register file.
- Arbitrates between ALU results and memory load returns.
- Extracts, aligns and extends load data and generates the per-byte write enables.
- Drives the register file write port from registers: address, byte enables, data and active-low chip select.

Parameters:
- STARVE_MAX, 3, consecutive load grants allowed while an ALU result waits before the ALU is forced through (1..15).
- ZERO_REG_EN, 0, when 1 any write to R0 is accepted but squashed (o_cs_b stays high).

Ports:
- i_clk  in  1  clock.
- i_rst_b  in  1  synchronous active-low reset.
- i_clk_en  in  1  global clock enable; when low, all state holds and both readies are low.
- i_alu_valid  in  1  ALU result valid.
- o_alu_rdy  out  1  ALU result accepted this cycle (combinational).
- i_alu_rd  in  4  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_ld_valid  in  1  load return valid.
- o_ld_rdy  out  1  load return accepted this cycle (combinational).
- i_ld_rd  in  4  load destination register.
- i_ld_data  in  32  raw aligned memory word.
- i_ld_boff  in  2  byte offset of the access.
- i_ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- i_ld_mode  in  2  00 zero-extend, 01 sign-extend, 10 insert (low lanes only), 11 treated as 00.
- o_waddr  out  4  register file write address.
- o_wen  out  4  register file byte write enables.
- o_din  out  32  register file write data.
- o_cs_b  out  1  register file chip select, active low.
- o_misalign  out  1  one-cycle pulse: misaligned load dropped.

Behaviour:
- Reset (i_rst_b low at a posedge): o_cs_b=1, o_wen=0, o_waddr=0, o_din=0, o_misalign=0, starve counter=0.
- While i_rst_b is low, o_alu_rdy=o_ld_rdy=0. Reset has priority over i_clk_en.
- Arbitration (combinational), with en = i_clk_en & i_rst_b and force = i_alu_valid & (cnt==STARVE_MAX):
  - o_ld_rdy = en & !force.
  - o_alu_rdy = en & (!i_ld_valid | force).
  - A load is accepted when i_ld_valid & o_ld_rdy; an ALU result when i_alu_valid & o_alu_rdy. At most one is accepted per cycle.
- Starve counter (updates only when i_clk_en is high):
  - Load accepted while i_alu_valid: increment, saturating at STARVE_MAX.
  - ALU accepted, or i_alu_valid low: clear to 0.
- Output register: at the posedge where an item is accepted (i_clk_en high), o_waddr/o_wen/o_din load and o_cs_b goes 0.
  - Otherwise, at an enabled edge, o_cs_b goes 1 and o_wen goes 0; o_waddr/o_din hold.
  - When i_clk_en is low, all outputs hold.
  - Latency: accept at edge N; write presented in cycle N+1; register file commits at edge N+1.
- ALU item: o_wen=4'b1111, o_din=i_alu_data.
- Load extraction:
  - Byte: b = data[8*boff +: 8].
  - Half: h = data[16*boff[1] +: 16].
  - Word: w = data.
- Load modes:
  - Zero-extend: o_wen=1111, value zero-extended.
  - Sign-extend: o_wen=1111, value sign-extended.
  - Insert: byte gives o_wen=0001, o_din={24'b0,b}; half gives o_wen=0011, o_din={16'b0,h}; word gives o_wen=1111.
- Misalignment:
  - Half with boff[0]=1, or word with boff!=0, is misaligned.
  - A misaligned load is accepted (handshake completes) but not written: o_cs_b=1, o_wen=0.
  - o_misalign=1 for exactly that cycle N+1.
- ZERO_REG_EN=1 and destination 0: accepted, o_cs_b stays 1, o_wen=0.
- Misaligned loads and R0-squashed items leave the starve counter behaving as a normal load or ALU acceptance.
- Back-to-back acceptances produce writes on consecutive cycles; no bubbles are inserted.

Test Plan:
- Reset with both valids high, i_rst_b=0 for 2 cycles -> readies 0, o_cs_b=1, o_wen=0. Release -> load granted first.
- ALU valid only, rd=5, data=0xDEADBEEF -> next cycle o_cs_b=0, o_waddr=5, o_wen=1111, o_din=0xDEADBEEF; following cycle o_cs_b=1.
- Load data=0x80FF7F01:
  - Byte, boff=3, sign-extend -> o_din=0xFFFFFF80, wen=1111.
  - Half, boff=2, insert -> o_din=0x000080FF, wen=0011.
  - Byte, boff=1, zero-extend -> 0x0000007F.
- Load half with boff=1 -> o_cs_b stays 1, o_misalign pulses for 1 cycle, o_ld_rdy was 1.
- Both valids held continuously, STARVE_MAX=3 -> grant sequence L,L,L,A,L,L,L,A; counter clears after each ALU grant.
- i_clk_en=0 for 3 cycles mid-stream -> outputs frozen, readies 0, no item lost or duplicated after re-enable. With ZERO_REG_EN=1, ALU rd=0 -> accepted, no write.
